// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle around the shared UART TX arbiter.
// master: the arbiter side; slave: requesters and transmitter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IDX_W   = 2
);
    logic [NUM_SRC*8-1:0] SrcData;
    logic [NUM_SRC-1:0]   SrcValid;
    logic [NUM_SRC-1:0]   SrcLast;
    logic [NUM_SRC-1:0]   SrcReady;
    logic [7:0]           TxData;
    logic                 TxEmpty;
    logic                 TxReadEnable;
    logic                 TxDataValid;
    logic [IDX_W-1:0]     Grant;
    logic                 Busy;

    modport master (
        input  SrcData, SrcValid, SrcLast, TxReadEnable,
        output SrcReady, TxData, TxEmpty, TxDataValid, Grant, Busy
    );

    modport slave (
        output SrcData, SrcValid, SrcLast, TxReadEnable,
        input  SrcReady, TxData, TxEmpty, TxDataValid, Grant, Busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Frame-locked round-robin arbiter sharing one UART transmitter among
// NUM_SRC byte-stream sources; looks like a FIFO read port to the TX.
// Optional: define UART_ARB_PRIO0_EN to make source 0 win every frame
// boundary at which it is requesting (pointer untouched by its frames).
module uart_tx_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic              Clk,
    input  logic              ResetN,
    uart_tx_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        ST_ARB,
        ST_ACCEPT,
        ST_OFFER,
        ST_DELIVER,
        ST_RELEASE
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   ptr_q;
    logic               busy_q;
    logic               last_q;
    logic               tx_empty_q;
    logic               tx_valid_q;
    logic [7:0]         tx_data_q;

    logic               pick_found_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic               cur_valid_c;
    logic               cur_last_c;
    logic [7:0]         cur_byte_c;
    logic [NUM_SRC-1:0] src_ready_c;

    // Next owner: first valid source after the pointer, wrapping.
    always_comb begin
        int j;
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        j            = 0;
        // Walk from the farthest candidate down so the nearest one wins.
        for (int k = int'(NUM_SRC); k >= 1; k--) begin
            j = (int'(ptr_q) + k) % int'(NUM_SRC);
            if (bus.SrcValid[j]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = IDX_W'(j);
            end
        end
`ifdef UART_ARB_PRIO0_EN
        if (bus.SrcValid[0]) begin
            pick_found_c = 1'b1;
            pick_idx_c   = '0;
        end
`endif
    end

    // Granted source's current offer and the accept strobe back to it.
    always_comb begin
        cur_valid_c = bus.SrcValid[grant_q];
        cur_last_c  = bus.SrcLast[grant_q];
        cur_byte_c  = bus.SrcData[int'(grant_q)*8 +: 8];
        src_ready_c = '0;
        if (state_q == ST_ACCEPT && cur_valid_c) begin
            src_ready_c[grant_q] = 1'b1;
        end
    end

    // Arbitration / one-byte holding FSM with registered TX-side outputs.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_q    <= ST_ARB;
            grant_q    <= '0;
            ptr_q      <= IDX_W'(NUM_SRC - 1);
            busy_q     <= 1'b0;
            last_q     <= 1'b0;
            tx_empty_q <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_valid_q <= 1'b0;
            case (state_q)
                ST_ARB: begin
                    if (pick_found_c) begin
                        grant_q <= pick_idx_c;
                        busy_q  <= 1'b1;
                        state_q <= ST_ACCEPT;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_ACCEPT: begin
                    if (cur_valid_c) begin
                        tx_data_q  <= cur_byte_c;
                        last_q     <= cur_last_c;
                        tx_empty_q <= 1'b0;
                        state_q    <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (bus.TxReadEnable) begin
                        tx_valid_q <= 1'b1;
                        tx_empty_q <= 1'b1;
                        state_q    <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    // A held read request must drop before the next byte.
                    if (!bus.TxReadEnable) begin
                        state_q <= last_q ? ST_RELEASE : ST_ACCEPT;
                    end
                end
                ST_RELEASE: begin
`ifdef UART_ARB_PRIO0_EN
                    if (grant_q != '0) begin
                        ptr_q <= grant_q;
                    end
`else
                    ptr_q   <= grant_q;
`endif
                    busy_q  <= 1'b0;
                    state_q <= ST_ARB;
                end
                default: begin
                    state_q <= ST_ARB;
                end
            endcase
        end
    end

    assign bus.SrcReady    = src_ready_c;
    assign bus.TxData      = tx_data_q;
    assign bus.TxEmpty     = tx_empty_q;
    assign bus.TxDataValid = tx_valid_q;
    assign bus.Grant       = grant_q;
    assign bus.Busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based sources, a transmitter model and
// a scoreboard predicting grant order and delivered bytes.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned IDX_W   = 2;

    logic Clk = 1'b0;
    logic ResetN;
    always #5 Clk = ~Clk;

    uart_tx_arbiter_if #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) bus_if ();

    uart_tx_arbiter #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus_if)
    );

    // Per-source pending bytes {last, data}, and bytes owed to the TX.
    logic [8:0] srcq [NUM_SRC][$];
    logic [8:0] expq [$];
    int         grant_log [$];
    logic [7:0] deliv_log [$];

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int m_ptr;
    bit in_frame;
    int owner;

    // Transmitter model knobs and state.
    bit tx_en = 1'b1;
    int tx_lat = 0;
    int tx_hold = 0;
    int wait_cnt = 0;
    int hold_cnt = 0;
    bit seen = 1'b0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic drive_srcs();
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (srcq[i].size() > 0) begin
                bus_if.SrcValid[i]       = 1'b1;
                bus_if.SrcData[8*i +: 8] = srcq[i][0][7:0];
                bus_if.SrcLast[i]        = srcq[i][0][8];
            end else begin
                bus_if.SrcValid[i]       = 1'b0;
                bus_if.SrcData[8*i +: 8] = 8'h00;
                bus_if.SrcLast[i]        = 1'b0;
            end
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < int'(NUM_SRC); i++) srcq[i].delete();
        expq.delete();
        in_frame = 1'b0;
        owner    = 0;
        m_ptr    = int'(NUM_SRC) - 1;
        seen     = 1'b0;
        wait_cnt = 0;
        hold_cnt = 0;
    endtask

    task automatic reset_dut();
        model_flush();
        bus_if.TxReadEnable = 1'b0;
        drive_srcs();
        ResetN = 1'b0;
        repeat (2) @(posedge Clk);
        #1 ResetN = 1'b1;
    endtask

    // Round-robin expectation from the set of sources with pending bytes.
    function automatic int rr_pick();
`ifdef UART_ARB_PRIO0_EN
        if (srcq[0].size() > 0) return 0;
`endif
        for (int k = 1; k <= int'(NUM_SRC); k++) begin
            int j;
            j = (m_ptr + k) % int'(NUM_SRC);
            if (srcq[j].size() > 0) return j;
        end
        return -1;
    endfunction

    // One clock: sample at negedge, check, update drives after posedge.
    task automatic tick();
        int acc_src;
        int exp_src;
        logic next_re;
        logic [NUM_SRC-1:0] onehot;
        logic [8:0] e;
        acc_src = -1;
        @(negedge Clk);
        next_re = bus_if.TxReadEnable;
        if (ResetN) begin
            onehot = '0;
            onehot[bus_if.Grant] = 1'b1;
            checks++;
            if (bus_if.SrcReady != '0 && (bus_if.SrcReady !== onehot || !bus_if.TxEmpty)) begin
                errors++;
                $display("FAIL src_ready_excl: SrcReady=%b Grant=%0d TxEmpty=%b, required one-hot at Grant with TxEmpty=1",
                         bus_if.SrcReady, bus_if.Grant, bus_if.TxEmpty);
            end
            checks++;
            if (bus_if.TxDataValid && !bus_if.TxReadEnable) begin
                errors++;
                $display("FAIL valid_without_re: TxDataValid=1 TxReadEnable=0, required no strobe");
            end
            checks++;
            if (seen && bus_if.TxReadEnable && !bus_if.TxEmpty) begin
                errors++;
                $display("FAIL early_offer: TxEmpty=0 while read request still held, required 1");
            end
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (bus_if.SrcReady[i]) begin
                    if (bus_if.SrcValid[i]) acc_src = i;
                    else begin
                        errors++;
                        $display("FAIL ready_without_valid: SrcReady[%0d]=1 SrcValid=0", i);
                    end
                end
            end
            if (acc_src >= 0) begin
                checks++;
                if (expq.size() != 0) begin
                    errors++;
                    $display("FAIL in_flight: accept with %0d undelivered bytes, required 0", expq.size());
                end
                if (!in_frame) begin
                    exp_src = rr_pick();
                    checks++;
                    if (acc_src != exp_src) begin
                        errors++;
                        $display("FAIL grant_order: granted %0d, required %0d", acc_src, exp_src);
                    end
                    in_frame = 1'b1;
                    owner    = acc_src;
                    grant_log.push_back(acc_src);
                end else begin
                    checks++;
                    if (acc_src != owner) begin
                        errors++;
                        $display("FAIL interleave: byte from %0d inside frame of %0d", acc_src, owner);
                    end
                end
                checks++;
                if (bus_if.Busy !== 1'b1 || bus_if.Grant !== IDX_W'(acc_src)) begin
                    errors++;
                    $display("FAIL lock_state: Busy=%b Grant=%0d, required Busy=1 Grant=%0d",
                             bus_if.Busy, bus_if.Grant, acc_src);
                end
                expq.push_back(srcq[acc_src][0]);
            end
            if (bus_if.TxDataValid) begin
                strobes++;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_strobe: TxDataValid with no byte owed, TxData=%h", bus_if.TxData);
                end else begin
                    e = expq.pop_front();
                    deliv_log.push_back(bus_if.TxData);
                    if (bus_if.TxData !== e[7:0]) begin
                        errors++;
                        $display("FAIL tx_data: TxData=%h, required %h", bus_if.TxData, e[7:0]);
                    end
                    if (e[8]) begin
                        in_frame = 1'b0;
`ifdef UART_ARB_PRIO0_EN
                        if (owner != 0) m_ptr = owner;
`else
                        m_ptr = owner;
`endif
                    end
                end
            end
        end
        if (bus_if.TxReadEnable) begin
            if (bus_if.TxDataValid) seen = 1'b1;
            if (seen) begin
                if (hold_cnt >= tx_hold) begin
                    next_re  = 1'b0;
                    seen     = 1'b0;
                    hold_cnt = 0;
                end else hold_cnt++;
            end
        end else if (tx_en && ResetN && !bus_if.TxEmpty) begin
            if (wait_cnt >= tx_lat) begin
                next_re  = 1'b1;
                wait_cnt = 0;
            end else wait_cnt++;
        end
        @(posedge Clk);
        #1;
        if (acc_src >= 0) void'(srcq[acc_src].pop_front());
        bus_if.TxReadEnable = next_re;
        drive_srcs();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        bit idle;
        n = 0;
        idle = 1'b0;
        while (!idle && n < budget) begin
            tick();
            n++;
            idle = !in_frame && expq.size() == 0 && !bus_if.TxReadEnable;
            for (int i = 0; i < int'(NUM_SRC); i++) if (srcq[i].size() != 0) idle = 1'b0;
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL timeout: not idle after %0d cycles", budget);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        model_flush();
        bus_if.TxReadEnable = 1'b0;
        drive_srcs();
        ResetN = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (bus_if.SrcReady !== '0) begin errors++; $display("FAIL rst_src_ready: %b, required 0", bus_if.SrcReady); end
        checks++;
        if (bus_if.TxEmpty !== 1'b1) begin errors++; $display("FAIL rst_tx_empty: %b, required 1", bus_if.TxEmpty); end
        checks++;
        if (bus_if.TxDataValid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: %b, required 0", bus_if.TxDataValid); end
        checks++;
        if (bus_if.TxData !== 8'h00) begin errors++; $display("FAIL rst_tx_data: %h, required 00", bus_if.TxData); end
        checks++;
        if (bus_if.Grant !== '0) begin errors++; $display("FAIL rst_grant: %0d, required 0", bus_if.Grant); end
        checks++;
        if (bus_if.Busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b, required 0", bus_if.Busy); end
        @(posedge Clk);
        #1 ResetN = 1'b1;
    endtask

    task automatic test_single();
        deliv_log.delete();
        grant_log.delete();
        srcq[1].push_back({1'b0, 8'h48});
        srcq[1].push_back({1'b1, 8'h69});
        drive_srcs();
        run_until_idle(200);
        checks++;
        if (deliv_log.size() != 2 || deliv_log[0] !== 8'h48 || deliv_log[1] !== 8'h69) begin
            errors++;
            $display("FAIL single_bytes: %0d bytes delivered, required 48,69", deliv_log.size());
        end
        checks++;
        if (bus_if.Grant !== IDX_W'(1) || bus_if.Busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: Grant=%0d Busy=%b, required Grant=1 Busy=0", bus_if.Grant, bus_if.Busy);
        end
    endtask

    task automatic test_rr_order();
        int exp_order [5];
`ifdef UART_ARB_PRIO0_EN
        exp_order = '{0, 0, 1, 2, 3};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        reset_dut();
        grant_log.delete();
        srcq[0].push_back({1'b1, 8'hA0});
        srcq[0].push_back({1'b1, 8'hA1});
        srcq[1].push_back({1'b1, 8'hB0});
        srcq[2].push_back({1'b1, 8'hC0});
        srcq[3].push_back({1'b1, 8'hD0});
        drive_srcs();
        run_until_idle(300);
        checks++;
        if (grant_log.size() != 5) begin
            errors++;
            $display("FAIL rr_count: %0d grants, required 5", grant_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (grant_log[i] != exp_order[i]) begin
                    errors++;
                    $display("FAIL rr_order: grant %0d was %0d, required %0d", i, grant_log[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_no_interleave();
        int n;
        reset_dut();
        grant_log.delete();
        srcq[2].push_back({1'b0, 8'h21});
        srcq[2].push_back({1'b0, 8'h22});
        srcq[2].push_back({1'b1, 8'h23});
        drive_srcs();
        n = 0;
        while (grant_log.size() == 0 && n < 20) begin tick(); n++; end
        srcq[0].push_back({1'b1, 8'h01});
        drive_srcs();
        run_until_idle(300);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 0) begin
            errors++;
            $display("FAIL lock_order: %0d grants first=%0d, required 2 then 0", grant_log.size(),
                     grant_log.size() > 0 ? grant_log[0] : -1);
        end
    endtask

    task automatic test_hold();
        int s0;
        s0 = strobes;
        tx_hold = 5;
        srcq[3].push_back({1'b0, 8'h11});
        srcq[3].push_back({1'b1, 8'h22});
        drive_srcs();
        run_until_idle(300);
        tx_hold = 0;
        checks++;
        if (strobes - s0 != 2) begin
            errors++;
            $display("FAIL hold_strobes: %0d strobes, required 2", strobes - s0);
        end
    endtask

    task automatic test_prio();
        int e0, e1;
`ifdef UART_ARB_PRIO0_EN
        e0 = 0; e1 = 2;
`else
        e0 = 2; e1 = 0;
`endif
        srcq[1].push_back({1'b1, 8'h31});
        drive_srcs();
        run_until_idle(200);
        grant_log.delete();
        srcq[0].push_back({1'b1, 8'h30});
        srcq[2].push_back({1'b1, 8'h32});
        drive_srcs();
        run_until_idle(300);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != e0 || grant_log[1] != e1) begin
            errors++;
            $display("FAIL prio_order: %0d grants first=%0d, required %0d then %0d", grant_log.size(),
                     grant_log.size() > 0 ? grant_log[0] : -1, e0, e1);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        tx_en = 1'b0;
        srcq[1].push_back({1'b1, 8'hA5});
        drive_srcs();
        n = 0;
        while (bus_if.TxEmpty && n < 20) begin tick(); n++; end
        checks++;
        if (bus_if.TxEmpty !== 1'b0 || bus_if.TxData !== 8'hA5) begin
            errors++;
            $display("FAIL mid_hold: TxEmpty=%b TxData=%h, required 0 and a5", bus_if.TxEmpty, bus_if.TxData);
        end
        model_flush();
        grant_log.delete();
        drive_srcs();
        bus_if.TxReadEnable = 1'b1;
        ResetN = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (bus_if.TxEmpty !== 1'b1 || bus_if.Busy !== 1'b0 || bus_if.TxDataValid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: TxEmpty=%b Busy=%b TxDataValid=%b, required 1,0,0",
                     bus_if.TxEmpty, bus_if.Busy, bus_if.TxDataValid);
        end
        @(posedge Clk);
        #1;
        ResetN = 1'b1;
        bus_if.TxReadEnable = 1'b0;
        tx_en = 1'b1;
        srcq[3].push_back({1'b1, 8'h3C});
        srcq[0].push_back({1'b1, 8'h0C});
        drive_srcs();
        run_until_idle(300);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0) begin
            errors++;
            $display("FAIL mid_regrant: %0d grants first=%0d, required source 0 first", grant_log.size(),
                     grant_log.size() > 0 ? grant_log[0] : -1);
        end
    endtask

    task automatic test_random();
        int nfr, s, len;
        for (int b = 0; b < 12; b++) begin
            nfr = int'($urandom_range(1, 3));
            for (int f = 0; f < nfr; f++) begin
                s   = int'($urandom_range(0, NUM_SRC - 1));
                len = int'($urandom_range(1, 4));
                for (int k = 0; k < len; k++) begin
                    srcq[s].push_back({(k == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                end
            end
            tx_lat  = int'($urandom_range(0, 3));
            tx_hold = int'($urandom_range(0, 2));
            drive_srcs();
            run_until_idle(600);
        end
        tx_lat  = 0;
        tx_hold = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_order();
        test_no_interleave();
        test_hold();
        test_prio();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_SRC byte-stream requesters (e.g. echo path, status reporter, debug dump).
- Sits between the requesters and the transmitter's FIFO-style read interface (data / empty / read-enable / data-valid) and presents itself to the transmitter as a FIFO.
- Frame-locked round-robin: once a source is granted, it owns the transmitter until its last byte has been accepted.

Parameters:
- NUM_SRC, 4, number of requesters; 2..8.
- IDX_W, 2, grant index width; must be ≥ clog2(NUM_SRC).

Ports:
- Clk  input  1  system clock.
- ResetN  input  1  synchronous, active-low reset, sampled on rising Clk.
- SrcData  input  NUM_SRC*8  byte from each source; source i on bits [8i+7:8i].
- SrcValid  input  NUM_SRC  source i has a byte on SrcData.
- SrcLast  input  NUM_SRC  byte from source i is the last byte of its frame.
- SrcReady  output  NUM_SRC  one-hot, single-cycle accept strobe to the granted source.
- TxData  output  8  byte offered to the transmitter.
- TxEmpty  output  1  low when a byte is held for the transmitter.
- TxReadEnable  input  1  transmitter read request; level, held until TxDataValid is seen.
- TxDataValid  output  1  one-cycle strobe; TxData is valid in that cycle.
- Grant  output  IDX_W  index of the current or most recent owner.
- Busy  output  1  high while a frame is locked.

Behaviour:
- Reset (ResetN=0 at a Clk edge):
  - state=ARB, SrcReady=0, TxEmpty=1, TxDataValid=0, TxData=0, Grant=0, Busy=0.
  - Round-robin pointer = NUM_SRC-1, so source 0 wins first.
  - Reset mid-frame drops the held byte and the lock. No strobe is issued in the reset cycle.
- States: ARB, ACCEPT, OFFER, DELIVER, RELEASE.
- ARB:
  - If any SrcValid is set, pick the first valid index after the pointer (wrapping NUM_SRC-1 -> 0).
  - Register Grant and set Busy=1 -> ACCEPT.
  - No valid source: stay in ARB with Busy=0.
- ACCEPT:
  - If SrcValid[Grant]: pulse SrcReady[Grant] for 1 cycle, latch the byte into TxData, latch SrcLast[Grant] into last_q, set TxEmpty=0 -> OFFER.
  - Otherwise wait. The lock is held and other sources are not served.
- OFFER:
  - When TxReadEnable=1: TxDataValid=1 for exactly one cycle and TxEmpty=1 in that same cycle -> DELIVER.
  - Latency from TxReadEnable sampled high to the TxDataValid strobe is 1 cycle.
- DELIVER:
  - Wait for TxReadEnable=0, so one request never causes a double delivery.
  - Then: if last_q -> RELEASE, else -> ACCEPT.
- RELEASE:
  - pointer <= Grant, Busy=0 -> ARB.
  - Same-cycle re-grant is not allowed. Minimum 2 idle cycles between frames.
- Single-byte frame (SrcLast with the first byte): lock is released after that one byte.
- Simultaneous requests in ARB: only the highest round-robin priority source is granted. The others keep SrcValid asserted; no request is lost.
- Source may assert SrcValid without holding it; an un-accepted byte is not captured.
- SrcReady is never asserted for a non-granted source, and never while TxEmpty=0.
- At most one byte is in flight. TxEmpty=0 implies the held byte is undelivered.
- TxDataValid while TxReadEnable=0 never occurs.

Optional Feature:
- Macro UART_ARB_PRIO0_EN.
- Defined:
  - Source 0 is urgent. In ARB, if SrcValid[0]=1 it wins regardless of the pointer.
  - A frame in progress is never pre-empted. Priority applies only at frame boundaries.
  - The pointer is not updated when source 0 releases, so round-robin order among the others is preserved.
- Undefined: pure round-robin as above, with source 0 treated like the rest.

Test Plan:
- Single source 1 sends frame 0x48,0x69(last); transmitter model asserts TxReadEnable after TxEmpty falls -> TxData 0x48 then 0x69, one TxDataValid each, Busy falls after the 2nd, Grant=1.
- Sources 0..3 all valid with 1-byte frames after reset -> grant order 0,1,2,3,0; SrcReady pulses are one-hot and never overlap.
- Source 2 in a 3-byte frame while source 0 is requesting -> bytes from 2 are not interleaved; source 0 is granted only after source 2's last byte is delivered.
- TxReadEnable held high 5 cycles after a strobe -> exactly one TxDataValid; the next byte is offered only after TxReadEnable drops.
- ResetN=0 while in OFFER with 0xA5 held -> next cycle TxEmpty=1, Busy=0, no TxDataValid; after release, source 0 is granted first.
- With UART_ARB_PRIO0_EN: last grant was 1, sources 0 and 2 both valid -> source 0 granted, then 2. Without the macro -> 2 then 0.
